// File: rtl/ulpi_rx_path.sv
// ulpi_rx_path: receive-side ULPI snooper. Decodes RX CMD status, frames received bytes
// into a FWFT byte FIFO, captures register reads. Define ULPI_RX_STATS_EN for packet/error counters.
module ulpi_rx_path #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_dir,
   input  logic       i_nxt,
   input  logic [7:0] i_data,
   input  logic       i_reg_rd_pend,
   output logic [7:0] o_reg_data,
   output logic       o_reg_valid,
   output logic [1:0] o_linestate,
   output logic [1:0] o_vbus,
   output logic       o_id,
   output logic       o_rx_active,
   output logic [7:0] o_rx_data,
   output logic       o_rx_valid,
   output logic       o_rx_last,
   output logic       o_rx_err,
   input  logic       i_rx_ready,
   output logic       o_overflow
`ifdef ULPI_RX_STATS_EN
   ,
   output logic [15:0] o_pkt_cnt,
   output logic [15:0] o_err_cnt
`endif
);

   // state | meaning
   // IDLE  | link owns the bus (dir=0); watch for dir rising
   // TURN  | turnaround after dir rise; bus not sampled
   // BUS   | PHY owns the bus; sample data bytes, RX CMDs, register reads

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]   DATA_LIM = (AW+1)'(FIFO_DEPTH - 1);
   localparam logic [AW:0]   FULL_LIM = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   typedef enum logic [1:0] {ST_IDLE, ST_TURN, ST_BUS} state_t;

   state_t state, state_nxt;

   logic       first_byte;
   logic       pkt_open;
   logic       pkt_drop;
   logic       stg_vld;
   logic [7:0] stg_data;
   logic       term_pend;

   logic [9:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   fifo_cnt;
   logic [9:0]    rd_word;

   logic       ev_byte, ev_cmd, ev_reg, ev_open, ev_abort, ev_end, end_err;
   logic [1:0] rx_event;
   logic       data_req, data_room, data_push, ovf_evt;
   logic       term_room, term_push, push, pop;
   logic [9:0] data_word, push_word;

   assign rx_event = i_data[5:4];

   always_comb begin
      state_nxt = state;
      ev_byte   = 1'b0;
      ev_cmd    = 1'b0;
      ev_reg    = 1'b0;
      ev_open   = 1'b0;
      ev_abort  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (i_dir) begin
               state_nxt = ST_TURN;
               ev_open   = i_nxt;
            end
         end
         ST_TURN: begin
            state_nxt = i_dir ? ST_BUS : ST_IDLE;
         end
         ST_BUS: begin
            if (!i_dir) begin
               state_nxt = ST_IDLE;
               ev_abort  = 1'b1;
            end else if (first_byte && i_reg_rd_pend && !i_nxt) begin
               ev_reg = 1'b1;
            end else if (i_nxt) begin
               ev_byte = 1'b1;
            end else begin
               ev_cmd = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign ev_end  = pkt_open && ((ev_cmd && rx_event != 2'b01) || ev_abort);
   assign end_err = ev_abort || (rx_event == 2'b11);

   assign o_rx_valid = (fifo_cnt != '0);
   assign pop        = o_rx_valid && i_rx_ready;
   assign rd_word    = mem[rd_ptr];
   assign o_rx_data  = o_rx_valid ? rd_word[9:2] : 8'h00;
   assign o_rx_last  = o_rx_valid && rd_word[1];
   assign o_rx_err   = o_rx_valid && rd_word[0];

   // The last slot is held back for the err+last terminator of an overflowing packet;
   // a pending terminator also blocks later data so entries stay in order.
   always_comb begin
      data_req  = 1'b0;
      data_word = '0;
      if (stg_vld && (ev_byte || ev_end)) begin
         data_req  = 1'b1;
         data_word = {stg_data, ev_end, ev_end & end_err};
      end
      data_room = ((fifo_cnt < DATA_LIM) || pop) && !term_pend;
      data_push = data_req && data_room;
      ovf_evt   = data_req && !data_room;
      term_room = (fifo_cnt < FULL_LIM) || pop;
      term_push = (term_pend || ovf_evt) && term_room;
      push      = data_push || term_push;
      push_word = data_push ? data_word : {8'h00, 2'b11};
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= ST_IDLE;
         first_byte  <= 1'b0;
         pkt_open    <= 1'b0;
         pkt_drop    <= 1'b0;
         stg_vld     <= 1'b0;
         stg_data    <= 8'h00;
         term_pend   <= 1'b0;
         o_overflow  <= 1'b0;
         o_reg_data  <= 8'h00;
         o_reg_valid <= 1'b0;
         o_linestate <= 2'b00;
         o_vbus      <= 2'b00;
         o_id        <= 1'b0;
         o_rx_active <= 1'b0;
      end else begin
         state <= state_nxt;

         if (state == ST_TURN && i_dir) begin
            first_byte <= 1'b1;
         end else if (state == ST_BUS) begin
            first_byte <= 1'b0;
         end

         o_reg_valid <= ev_reg;
         if (ev_reg) begin
            o_reg_data <= i_data;
         end

         if (ev_cmd) begin
            o_linestate <= i_data[1:0];
            o_vbus      <= i_data[3:2];
            o_id        <= i_data[6];
            o_rx_active <= i_data[4];
         end else if (ev_open) begin
            o_rx_active <= 1'b1;
         end

         if (ev_end) begin
            pkt_open <= 1'b0;
         end else if (ev_open || ev_byte || (ev_cmd && rx_event == 2'b01)) begin
            pkt_open <= 1'b1;
         end

         if (ev_end) begin
            pkt_drop <= 1'b0;
         end else if (ovf_evt) begin
            pkt_drop <= 1'b1;
         end

         if (ev_end || ovf_evt) begin
            stg_vld <= 1'b0;
         end else if (ev_byte && !pkt_drop) begin
            stg_vld  <= 1'b1;
            stg_data <= i_data;
         end

         term_pend <= (term_pend || ovf_evt) && !term_push;

         if (ovf_evt) begin
            o_overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
            2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) begin
         mem[wr_ptr] <= push_word;
      end
   end

`ifdef ULPI_RX_STATS_EN
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_pkt_cnt <= 16'h0000;
         o_err_cnt <= 16'h0000;
      end else if (ev_end) begin
         if (o_pkt_cnt != 16'hFFFF) begin
            o_pkt_cnt <= o_pkt_cnt + 16'd1;
         end
         if ((end_err || pkt_drop || ovf_evt) && o_err_cnt != 16'hFFFF) begin
            o_err_cnt <= o_err_cnt + 16'd1;
         end
      end
   end
`endif

endmodule
